// File: rtl/mmio_timer_port.sv
// Memory-mapped output latch and prescaled 16-bit down-counter timer.
// Sits on the CPU memory bus beside main memory. Eight byte registers start
// at BASE. Reads are combinational. Writes take effect on the rising clock edge.
module mmio_timer_port #(
  parameter logic [15:0] BASE     = 16'hD000,
  parameter int unsigned PRESCALE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        rW,
  output logic        sel,
  output logic [7:0]  rdata,
  output logic        irq_n,
  output logic [7:0]  port_out
);

  localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t        state, state_nxt;

  logic [15:0]   off;
  logic [2:0]    reg_off;
  logic          wr_en, rd_en;
  logic          wr_port, wr_ctrl, wr_rl, wr_rh, wr_stat, rd_cnt_l;

  logic [7:0]    port_q;
  logic [2:0]    ctrl_q;     // {IE, AUTO, EN}
  logic [15:0]   reload_q;
  logic [15:0]   count_q;
  logic [7:0]    shadow_q;
  logic          exp_q;
  logic [PW-1:0] pre_q;
  logic          irq_q;

  logic          running, tick, expire;

  assign off      = addr - BASE;
  assign sel      = (off < 16'd8);
  assign reg_off  = off[2:0];
  assign wr_en    = sel & ~rW;
  assign rd_en    = sel & rW;
  assign irq_n    = irq_q;
  assign port_out = port_q;

  // Decode the register strobes for the current bus cycle.
  always_comb begin
    wr_port  = wr_en && (reg_off == 3'd0);
    wr_ctrl  = wr_en && (reg_off == 3'd1);
    wr_rl    = wr_en && (reg_off == 3'd2);
    wr_rh    = wr_en && (reg_off == 3'd3);
    wr_stat  = wr_en && (reg_off == 3'd6);
    rd_cnt_l = rd_en && (reg_off == 3'd4);
  end

  // State register for the timer FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= STOPPED;
    else        state <= state_nxt;
  end

  // Next state: a CTRL write decides EN directly; otherwise a one-shot expiry stops the timer.
  always_comb begin
    state_nxt = state;
    case (state)
      STOPPED: if (wr_ctrl && wdata[0]) state_nxt = RUNNING;
      RUNNING: begin
        if (wr_ctrl)                     state_nxt = wdata[0] ? RUNNING : STOPPED;
        else if (expire && !ctrl_q[1])   state_nxt = STOPPED;
      end
      default: state_nxt = STOPPED;
    endcase
  end

  // FSM outputs: tick at the last prescaler count, and expiry when the tick lands on zero.
  always_comb begin
    running = (state == RUNNING);
    tick    = running && (pre_q == PRE_LAST);
    expire  = tick && (count_q == '0);
  end

  // Prescaler: free-runs while RUNNING and restarts on a RELOAD_H write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       pre_q <= '0;
    else if (!running || wr_rh || tick) pre_q <= '0;
    else                              pre_q <= pre_q + PW'(1);
  end

  // Counter: a RELOAD_H write takes priority over a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '1;
    end else if (wr_rh) begin
      count_q <= {wdata, reload_q[7:0]};
    end else if (tick) begin
      if (count_q != '0)  count_q <= count_q - 16'd1;
      else if (ctrl_q[1]) count_q <= reload_q;
    end
  end

  // CTRL: written by the CPU. A one-shot expiry clears EN unless a CTRL write lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ctrl_q    <= '0;
    else if (wr_ctrl)                ctrl_q    <= wdata[2:0];
    else if (expire && !ctrl_q[1])   ctrl_q[0] <= 1'b0;
  end

  // Plain CPU-written registers, plus the COUNT_H snapshot taken when COUNT_L is read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q   <= '0;
      reload_q <= '1;
      shadow_q <= '0;
    end else begin
      if (wr_port)  port_q         <= wdata;
      if (wr_rl)    reload_q[7:0]  <= wdata;
      if (wr_rh)    reload_q[15:8] <= wdata;
      if (rd_cnt_l) shadow_q       <= count_q[15:8];
    end
  end

  // Sticky expiry flag. A new expiry beats a write-one-to-clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      exp_q <= 1'b0;
    else if (expire)                 exp_q <= 1'b1;
    else if (wr_stat && wdata[0])    exp_q <= 1'b0;
  end

  // Interrupt request is registered from the flag and the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b1;
    else        irq_q <= ~(exp_q & ctrl_q[2]);
  end

  // Read mux. It drives zero unless this block is addressed for a read.
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (reg_off)
        3'd0:    rdata = port_q;
        3'd1:    rdata = {5'b0, ctrl_q};
        3'd2:    rdata = reload_q[7:0];
        3'd3:    rdata = reload_q[15:8];
        3'd4:    rdata = count_q[7:0];
        3'd5:    rdata = shadow_q;
        3'd6:    rdata = {7'b0, exp_q};
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer_port.sv
// Testbench for mmio_timer_port with PRESCALE=4. It checks the DUT against a
// register-level behavioural model. Directed scenarios are followed by random bus traffic.
module tb_mmio_timer_port;

  localparam logic [15:0] B  = 16'hD000;
  localparam int          PS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        rW;
  logic        sel;
  logic [7:0]  rdata;
  logic        irq_n;
  logic [7:0]  port_out;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mmio_timer_port #(.BASE(B), .PRESCALE(PS)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .rW(rW),
    .sel(sel), .rdata(rdata), .irq_n(irq_n), .port_out(port_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [7:0]  port;
    logic        en, auto_rl, ie;
    logic [15:0] reload;
    logic [15:0] count;
    logic [7:0]  shadow;
    logic        expf;
    int          pre;
    logic        irq_n;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t m_reset();
    mstate_t s;
    s = '0;
    s.reload = 16'hFFFF;
    s.count  = 16'hFFFF;
    s.irq_n  = 1'b1;
    return s;
  endfunction

  function automatic int m_off(logic [15:0] a);
    return int'(a) - int'(B);
  endfunction

  function automatic logic m_sel(logic [15:0] a);
    return (m_off(a) >= 0) && (m_off(a) <= 7);
  endfunction

  function automatic logic [7:0] m_read(mstate_t s, logic [15:0] a, logic r);
    if (!r || !m_sel(a)) return 8'h00;
    case (m_off(a))
      0: return s.port;
      1: return {5'b0, s.ie, s.auto_rl, s.en};
      2: return s.reload[7:0];
      3: return s.reload[15:8];
      4: return s.count[7:0];
      5: return s.shadow;
      6: return {7'b0, s.expf};
      default: return 8'h00;
    endcase
  endfunction

  function automatic mstate_t m_next(mstate_t s, logic [15:0] a, logic [7:0] d, logic r);
    mstate_t n;
    int  o;
    bit  wr, tick, expire;
    n      = s;
    o      = m_off(a);
    wr     = m_sel(a) && !r;
    tick   = s.en && (s.pre == PS - 1);
    expire = tick && (s.count == 0);
    // timer progress
    if (s.en) begin
      n.pre = tick ? 0 : s.pre + 1;
      if (tick) begin
        if (s.count != 0)   n.count = s.count - 1;
        else if (s.auto_rl) n.count = s.reload;
        else                n.en    = 1'b0;
      end
    end else begin
      n.pre = 0;
    end
    if (expire) n.expf = 1'b1;
    n.irq_n = !(s.expf && s.ie);
    if (m_sel(a) && r && o == 4) n.shadow = s.count[15:8];
    // bus writes
    if (wr) begin
      case (o)
        0: n.port = d;
        1: begin n.en = d[0]; n.auto_rl = d[1]; n.ie = d[2]; end
        2: n.reload[7:0] = d;
        3: begin n.reload[15:8] = d; n.count = {d, s.reload[7:0]}; n.pre = 0; end
        6: if (d[0] && !expire) n.expf = 1'b0;
        default: ;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= m_reset();
    else        m <= m_next(m, addr, wdata, rW);
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Compare every cycle at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("sel",      {15'b0, sel},   {15'b0, m_sel(addr)});
      check("rdata",    {8'b0, rdata},  {8'b0, m_read(m, addr, rW)});
      check("irq_n",    {15'b0, irq_n}, {15'b0, m.irq_n});
      check("port_out", {8'b0, port_out}, {8'b0, m.port});
    end
  end

  // ---------------- bus tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle();
    addr  = 16'h0000;
    wdata = 8'h00;
    rW    = 1'b1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; wdata = d; rW = 1'b0;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] req, input string nm);
    addr = a; rW = 1'b1;
    #1 check(nm, {8'b0, rdata}, {8'b0, req});
    @(posedge clk); #1;
    idle();
  endtask

  task automatic peek(input logic [15:0] a, input logic [7:0] req, input string nm);
    addr = a; rW = 1'b1;
    #1 check(nm, {8'b0, rdata}, {8'b0, req});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    int          o;

    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // reset state
    check("rst_irq_n", {15'b0, irq_n}, 16'h0001);
    check("rst_port", {8'b0, port_out}, 16'h0000);
    rd(B + 16'd1, 8'h00, "rst_ctrl");
    rd(B + 16'd3, 8'hFF, "rst_reload_h");
    rd(B + 16'd6, 8'h00, "rst_status");

    // output latch and decode boundaries
    wr(B, 8'hA5);
    check("port_a5", {8'b0, port_out}, 16'h00A5);
    rd(B, 8'hA5, "rd_port");
    addr = B + 16'd8; rW = 1'b1;
    #1 check("sel_b8", {15'b0, sel}, 16'h0000);
    check("rdata_b8", {8'b0, rdata}, 16'h0000);
    addr = B - 16'd1;
    #1 check("sel_bm1", {15'b0, sel}, 16'h0000);
    step(1); idle();

    // shadowed COUNT_H
    wr(B + 16'd2, 8'h34);
    wr(B + 16'd3, 8'h12);
    rd(B + 16'd4, 8'h34, "count_l_1234");
    wr(B + 16'd3, 8'h56);
    rd(B + 16'd5, 8'h12, "shadow_12");

    // one-shot expiry from count 3
    wr(B + 16'd2, 8'h03);
    wr(B + 16'd3, 8'h00);
    wr(B + 16'd1, 8'h05);
    addr = B + 16'd6; rW = 1'b1;
    step(15);
    check("oneshot_exp_early", {8'b0, rdata}, 16'h0000);
    step(1);
    check("oneshot_exp_16", {8'b0, rdata}, 16'h0001);
    check("oneshot_irq_still_hi", {15'b0, irq_n}, 16'h0001);
    step(1);
    check("oneshot_irq_lo", {15'b0, irq_n}, 16'h0000);
    idle();
    rd(B + 16'd4, 8'h00, "oneshot_count0");
    rd(B + 16'd1, 8'h04, "oneshot_ctrl04");

    // auto-reload with W1C colliding with expiry
    wr(B + 16'd6, 8'h01);
    wr(B + 16'd2, 8'h02);
    wr(B + 16'd3, 8'h00);
    wr(B + 16'd1, 8'h07);
    step(11);
    wr(B + 16'd6, 8'h01);
    peek(B + 16'd6, 8'h01, "auto_set_wins");
    peek(B + 16'd4, 8'h02, "auto_reloaded");
    wr(B + 16'd6, 8'h01);
    peek(B + 16'd6, 8'h00, "auto_w1c");
    check("auto_irq_lo", {15'b0, irq_n}, 16'h0000);
    step(1);
    check("auto_irq_hi", {15'b0, irq_n}, 16'h0001);
    idle();
    wr(B + 16'd1, 8'h00);

    // RELOAD_H write on a tick edge, then off a tick edge
    wr(B + 16'd2, 8'h10);
    wr(B + 16'd3, 8'h00);
    wr(B + 16'd1, 8'h01);
    wr(B + 16'd2, 8'h20);
    step(2);
    wr(B + 16'd3, 8'h00);
    peek(B + 16'd4, 8'h20, "rh_on_tick");
    step(3);
    check("rh_hold", {8'b0, rdata}, 16'h0020);
    step(1);
    check("rh_first_dec", {8'b0, rdata}, 16'h001F);
    step(1); idle();
    wr(B + 16'd3, 8'h00);
    peek(B + 16'd4, 8'h20, "rh_off_tick");
    step(3);
    check("rh_restart_hold", {8'b0, rdata}, 16'h0020);
    step(1);
    check("rh_restart_dec", {8'b0, rdata}, 16'h001F);
    idle();
    wr(B + 16'd1, 8'h00);

    // reset mid-run
    wr(B, 8'h3C);
    wr(B + 16'd2, 8'h00);
    wr(B + 16'd3, 8'h00);
    wr(B + 16'd1, 8'h07);
    step(6);
    check("run_irq_lo", {15'b0, irq_n}, 16'h0000);
    rst_n = 1'b0;
    #1 check("midrst_irq_n", {15'b0, irq_n}, 16'h0001);
    check("midrst_port", {8'b0, port_out}, 16'h0000);
    #5 rst_n = 1'b1;
    step(1);
    rd(B + 16'd5, 8'h00, "midrst_shadow");
    rd(B + 16'd4, 8'hFF, "midrst_count_l");
    rd(B + 16'd5, 8'hFF, "midrst_shadow_ff");
    rd(B + 16'd1, 8'h00, "midrst_ctrl");

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step(1);
        continue;
      end
      o = int'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(0, 16'hCFFF));
      else                           a = B + 16'(o);
      d = 8'($urandom);
      if (o == 1 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      if (o == 2) d = 8'($urandom_range(0, 12));
      if (o == 3) d = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 2)) : 8'h00;
      addr  = a;
      wdata = d;
      rW    = 1'($urandom_range(0, 1));
      step(1);
    end
    idle();
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
